exception_spr_unit: RTL
=======================

Name: exception_spr_unit

Overview:
Holds the exception-related special-purpose registers of the or1300 core: SR, ESR0, EPCR0, EEAR0 and a latched exception-reason register. It receives the entry and exit events from the exception/branch logic and applies them: save/restore of SR, capture of EPCR/EEAR, and nesting tracking. It feeds SR and EPCR back to that logic every cycle. It also serves the core's SPR read/write port for these registers and takes flag updates from the execute stage.

Parameters:
MAX_DEPTH, 4, nesting depth at which nestedException asserts (range 1..15)
SR_RESET, 32'h00008001, SR value after reset (SM=1, FO=1, all enables 0)

Ports:
clock  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 forces reset state immediately
stall  in  1  pipeline stall; when 1, no state update except the reset path
exceptionTaken  in  1  exception entry this cycle
exceptionFinished  in  1  rfe completing this cycle
epcrNext  in  32  PC value to save on entry
eearNext  in  32  effective address to save on entry
exceptionReason  in  14  one-hot cause of the current entry
isDelaySlotIsn  in  1  faulting instruction is in a delay slot
sprWe  in  1  SPR write strobe
sprRe  in  1  SPR read strobe
sprAddress  in  16  SPR address
sprDataIn  in  32  SPR write data
sprDataOut  out  32  registered SPR read data
sprReadValid  out  1  sprDataOut valid, one cycle after an accepted sprRe
flagWe, flagIn  in  1,1  SR[9] (F) update
carryWe, carryIn  in  1,1  SR[10] (CY) update
overflowWe, overflowIn  in  1,1  SR[11] (OV) update
supervisionRegister  out  32  current SR
exceptionPcRegister  out  32  current EPCR0
exceptionEffectiveAddressRegister  out  32  current EEAR0
exceptionSrRegister  out  32  current ESR0
exceptionDepth  out  4  current nesting depth
nestedException  out  1  exceptionDepth >= MAX_DEPTH

Behaviour:
- Reset (reset=0, async):
  - SR=SR_RESET; ESR=0, EPCR=0, EEAR=0, reason=0.
  - depth=0, sprDataOut=0, sprReadValid=0.
- SR bit 15 (FO) always reads and holds 1; writes to it are ignored.
- SPR map (group 0):
  - 0x0011 SR
  - 0x0020 EPCR0
  - 0x0030 EEAR0
  - 0x0040 ESR0
  - 0x0050 reason (read-only, zero-extended)
  - Unmapped addresses read 0; writes to them are ignored.
- Privilege: SPR writes take effect only when SR[0] (SM)=1; otherwise they are dropped silently.
- Per-cycle update priority when stall=0 (highest first):
  1. exceptionTaken:
     - ESR <= SR with the F/CY/OV updates of this cycle already merged.
     - SR <= that value with SM=1, IEE(2)=0, TEE(1)=0, DSX(13)=isDelaySlotIsn.
     - EPCR <= epcrNext; EEAR <= eearNext; reason <= exceptionReason.
     - depth <= depth+1, saturating at 15.
  2. exceptionFinished (only when exceptionTaken=0):
     - SR <= ESR with FO forced to 1.
     - depth <= depth-1, saturating at 0.
  3. sprWe to a mapped address: target register <= sprDataIn.
  4. F/CY/OV write enables apply to SR bits 9/10/11. They are ignored when item 2 or an SR SPR write occurs in the same cycle; the SPR write wins over flag updates.
- stall=1: every register holds. sprReadValid deasserts to 0; sprDataOut holds.
- Reads: an accepted sprRe (stall=0) loads sprDataOut with the pre-update value of the addressed register and sets sprReadValid=1 for exactly one cycle. Read latency is 1 cycle.
- Simultaneous sprRe and sprWe to the same address: read returns the old value.
- exceptionTaken and exceptionFinished both high: treated as entry only; depth increments.
- Outputs supervisionRegister, exceptionPcRegister, exceptionEffectiveAddressRegister, exceptionSrRegister are direct register outputs with no combinational bypass. A change is visible the cycle after the update.
- nestedException is combinational from depth. It is informational only and never blocks an update.
- Reset asserted mid-exception clears depth and the saved state immediately, regardless of stall.

Test Plan:
1. Release reset, no activity -> SR=0x00008001, EPCR=0, depth=0, nestedException=0.
2. SM=1, sprWe SR=0x00000007, then exceptionTaken with epcrNext=0x00001234, eearNext=0x0000ABCD, isDelaySlotIsn=1, reason=0x0080 -> ESR=0x00008007, SR=0x00002001|0x8000=0x0000A001, EPCR=0x00001234, EEAR=0x0000ABCD, depth=1; sprRe 0x0050 -> sprDataOut=0x00000080 one cycle later with sprReadValid=1.
3. Following scenario 2, assert exceptionFinished -> SR=0x00008007, depth=0; a further exceptionFinished at depth 0 keeps depth=0.
4. SM=0: sprWe 0x0020 data 0xDEADBEEF -> EPCR unchanged. carryWe=1, carryIn=1 -> SR[10]=1 next cycle.
5. stall=1 with exceptionTaken=1 and sprRe=1 for 3 cycles -> no register changes, sprReadValid=0. Drop stall -> entry applied once.
6. Four back-to-back entries with MAX_DEPTH=4 -> nestedException=1 after the fourth. Pulse reset low mid-cycle -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/exception_spr_unit_if.sv
// SPR read/write port between the core and the exception SPR unit.
// The master drives the strobes and address; the slave returns registered read data.
interface exception_spr_unit_if;
    logic        sprWe;
    logic        sprRe;
    logic [15:0] sprAddress;
    logic [31:0] sprDataIn;
    logic [31:0] sprDataOut;
    logic        sprReadValid;

    modport master (
        output sprWe, sprRe, sprAddress, sprDataIn,
        input  sprDataOut, sprReadValid
    );

    modport slave (
        input  sprWe, sprRe, sprAddress, sprDataIn,
        output sprDataOut, sprReadValid
    );
endinterface

// File: rtl/exception_spr_unit.sv
// Exception special-purpose registers (SR, ESR0, EPCR0, EEAR0, reason) with entry/exit
// handling, nesting depth tracking and a one-cycle-latency SPR read/write port.
module exception_spr_unit #(
    parameter int unsigned MAX_DEPTH = 4,
    parameter logic [31:0] SR_RESET  = 32'h00008001
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    exceptionTaken,
    input  logic                    exceptionFinished,
    input  logic [31:0]             epcrNext,
    input  logic [31:0]             eearNext,
    input  logic [13:0]             exceptionReason,
    input  logic                    isDelaySlotIsn,
    exception_spr_unit_if.slave     spr,
    input  logic                    flagWe,
    input  logic                    flagIn,
    input  logic                    carryWe,
    input  logic                    carryIn,
    input  logic                    overflowWe,
    input  logic                    overflowIn,
    output logic [31:0]             supervisionRegister,
    output logic [31:0]             exceptionPcRegister,
    output logic [31:0]             exceptionEffectiveAddressRegister,
    output logic [31:0]             exceptionSrRegister,
    output logic [3:0]              exceptionDepth,
    output logic                    nestedException
);

    localparam logic [31:0] FoMask     = 32'h00008000;
    localparam logic [15:0] AddrSr     = 16'h0011;
    localparam logic [15:0] AddrEpcr   = 16'h0020;
    localparam logic [15:0] AddrEear   = 16'h0030;
    localparam logic [15:0] AddrEsr    = 16'h0040;
    localparam logic [15:0] AddrReason = 16'h0050;

    logic [31:0] srQ, srD;
    logic [31:0] esrQ, esrD;
    logic [31:0] epcrQ, epcrD;
    logic [31:0] eearQ, eearD;
    logic [13:0] reasonQ, reasonD;
    logic [3:0]  depthQ, depthD;
    logic [31:0] dataOutQ;
    logic        readValidQ;

    logic [31:0] srFlagged;
    logic [31:0] readData;
    logic        writeAllowed;

    always_comb begin
        srFlagged = srQ;
        if (flagWe)     srFlagged[9]  = flagIn;
        if (carryWe)    srFlagged[10] = carryIn;
        if (overflowWe) srFlagged[11] = overflowIn;
    end

    // Reads always see the register contents from before this cycle's update.
    always_comb begin
        readData = 32'h0;
        case (spr.sprAddress)
            AddrSr:     readData = srQ;
            AddrEpcr:   readData = epcrQ;
            AddrEear:   readData = eearQ;
            AddrEsr:    readData = esrQ;
            AddrReason: readData = {18'h0, reasonQ};
            default:    readData = 32'h0;
        endcase
    end

    assign writeAllowed = spr.sprWe && srQ[0];

    always_comb begin
        srD     = srQ;
        esrD    = esrQ;
        epcrD   = epcrQ;
        eearD   = eearQ;
        reasonD = reasonQ;
        depthD  = depthQ;
        if (exceptionTaken) begin
            esrD     = srFlagged;
            srD      = srFlagged | FoMask;
            srD[0]   = 1'b1;
            srD[1]   = 1'b0;
            srD[2]   = 1'b0;
            srD[13]  = isDelaySlotIsn;
            epcrD    = epcrNext;
            eearD    = eearNext;
            reasonD  = exceptionReason;
            depthD   = (depthQ == 4'hF) ? 4'hF : depthQ + 4'h1;
        end else if (exceptionFinished) begin
            srD    = esrQ | FoMask;
            depthD = (depthQ == 4'h0) ? 4'h0 : depthQ - 4'h1;
        end else begin
            // Flag updates apply unless an SR write overrides them below.
            srD = srFlagged;
            if (writeAllowed) begin
                case (spr.sprAddress)
                    AddrSr:   srD   = spr.sprDataIn | FoMask;
                    AddrEpcr: epcrD = spr.sprDataIn;
                    AddrEear: eearD = spr.sprDataIn;
                    AddrEsr:  esrD  = spr.sprDataIn;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            srQ        <= SR_RESET | FoMask;
            esrQ       <= 32'h0;
            epcrQ      <= 32'h0;
            eearQ      <= 32'h0;
            reasonQ    <= 14'h0;
            depthQ     <= 4'h0;
            dataOutQ   <= 32'h0;
            readValidQ <= 1'b0;
        end else if (stall) begin
            readValidQ <= 1'b0;
        end else begin
            srQ        <= srD;
            esrQ       <= esrD;
            epcrQ      <= epcrD;
            eearQ      <= eearD;
            reasonQ    <= reasonD;
            depthQ     <= depthD;
            readValidQ <= spr.sprRe;
            if (spr.sprRe) dataOutQ <= readData;
        end
    end

    assign spr.sprDataOut                    = dataOutQ;
    assign spr.sprReadValid                  = readValidQ;
    assign supervisionRegister               = srQ;
    assign exceptionPcRegister               = epcrQ;
    assign exceptionEffectiveAddressRegister = eearQ;
    assign exceptionSrRegister               = esrQ;
    assign exceptionDepth                    = depthQ;
    assign nestedException                   = 32'(depthQ) >= MAX_DEPTH;

endmodule
